perceptron_trainer: RTL and testbench
=====================================

// Module: perceptron_trainer
// PURPOSE
//  Training controller directly downstream of the dataset reader. Drives the
//  reader's init/next strobes, consumes each sample (X1, X2, T) and EOF, and
//  trains a 2-input perceptron with the rule W += ETA*t*x on misclassification.
//  Repeats epochs until one epoch makes no update or MAX_EPOCHS is reached.
// PARAMETERS
//  XW          7   sample width; X1/X2 are signed two's complement
//  WW          10  weight/bias width, signed, saturating
//  MAX_EPOCHS  50  epoch limit (>=1)
//  ETA         1   integer learning rate (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      begin training; sampled in IDLE/DONE only
//  X1, X2     in   XW     sample features from reader
//  T          in   2      target: 01=+1, 11=-1, 00/10=skip (no update)
//  EOF        in   1      reader end-of-file flag
//  init       out  1      1-cycle pulse: reader reopens file, loads sample 0
//  next       out  1      1-cycle pulse: reader loads next sample or sets EOF
//  W1, W2, B  out  WW     current weights and bias (signed)
//  epoch      out  8      current/last epoch number, 1-based
//  busy       out  1      high in all states except IDLE/DONE
//  done       out  1      high in DONE
//  converged  out  1      valid with done: 1 = last epoch made no update
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; init/next/busy/done/converged=0;
//    W1=W2=B=0; epoch=0. Asserting reset mid-training aborts immediately.
//    The reader is not reset; the next start re-initialises it via init.
//  - Reader contract: sample and EOF are registered on the edge that samples
//    init/next high. Both are valid in the following cycle (WAIT).
//  - FSM (one state per cycle unless noted):
//    IDLE/DONE: start=1 -> clear W1/W2/B, epoch=1, changed=0, done=0 -> INIT.
//    INIT:  init=1 -> WAIT.
//    WAIT:  EOF=1 -> END_EPOCH; else -> CALC.
//    CALC:  net <= W1*X1 + W2*X2 + B. All operands are sign-extended to
//           WW+XW+2 bits, so the sum cannot overflow -> UPDATE.
//    UPDATE: y = (net >= 0) ? +1 : -1. If T is valid and y != t:
//           W1 += ETA*t*X1, W2 += ETA*t*X2, B += ETA*t; set changed.
//           -> FETCH.
//    FETCH: next=1 -> WAIT.
//    END_EPOCH: changed=0 -> DONE, converged=1.
//           Else epoch==MAX_EPOCHS -> DONE, converged=0.
//           Else changed=0, epoch++ -> INIT.
//  - Sample throughput: 4 cycles (WAIT, CALC, UPDATE, FETCH). next rises
//    exactly 4 cycles after the init cycle, then every 4 cycles.
//  - Each update result saturates to [-2^(WW-1), 2^(WW-1)-1] independently.
//  - Skip targets (00, 10) never update and never set changed.
//  - start while busy is ignored. Weights are held in DONE until the next start.
//  - init and next are never high together, and never high in consecutive cycles.
//  - The sample that is current when EOF rises was already processed on the
//    previous pass; it is not processed again.
// TESTING
//  1 Reset: drop rst in the CALC cycle -> init=next=busy=0, W1=W2=B=0,
//    state IDLE without waiting for a clock edge; rst high plus start restarts
//    cleanly.
//  2 Handshake: start pulse -> init high for 1 cycle, the first next exactly
//    4 cycles later, next period 4, init/next never overlapping.
//  3 Single update: file "0000011 0000010 11" -> epoch 1 gives W1=-3, W2=-2,
//    B=-1; epoch 2 makes no update -> done=1, converged=1, epoch=2.
//  4 Bipolar AND (4 lines, +/-1 inputs) -> done=1, converged=1,
//    epoch<=MAX_EPOCHS, and every sample is classified correctly by the
//    final weights.
//  5 XOR with MAX_EPOCHS=5 -> done=1, converged=0, epoch=5.
//  6 Saturation, WW=4: sample "0111111 0000000 11" -> W1=-8 (clamped),
//    W2=0, B=-1. A start during busy has no effect.

Source files
------------

// File: rtl/perceptron_trainer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : perceptron_trainer_if
//  Description : Reader handshake, control and status bundle for the
//                perceptron trainer.
//  Revision    : 1.0
// ============================================================================
interface perceptron_trainer_if #(
    parameter int XW = 7,
    parameter int WW = 10
);
    logic                 i_start;
    logic signed [XW-1:0] i_x1;
    logic signed [XW-1:0] i_x2;
    logic        [1:0]    i_t;
    logic                 i_eof;
    logic                 o_init;
    logic                 o_next;
    logic signed [WW-1:0] o_w1;
    logic signed [WW-1:0] o_w2;
    logic signed [WW-1:0] o_b;
    logic        [7:0]    o_epoch;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_converged;

    modport master (
        input  i_start, i_x1, i_x2, i_t, i_eof,
        output o_init, o_next, o_w1, o_w2, o_b, o_epoch, o_busy, o_done, o_converged
    );

    modport slave (
        output i_start, i_x1, i_x2, i_t, i_eof,
        input  o_init, o_next, o_w1, o_w2, o_b, o_epoch, o_busy, o_done, o_converged
    );
endinterface
`default_nettype wire

// File: rtl/perceptron_trainer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : perceptron_trainer
//  Description : Drives a dataset reader and trains a 2-input perceptron with
//                saturating weights, repeating epochs until convergence.
//  Revision    : 1.0
// ============================================================================
module perceptron_trainer #(
    parameter int XW         = 7,
    parameter int WW         = 10,
    parameter int MAX_EPOCHS = 50,
    parameter int ETA        = 1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    perceptron_trainer_if.master bus
);
    localparam int NW = WW + XW + 2;
    localparam int EW = $clog2(ETA + 1);
    localparam int UW = WW + XW + EW + 2;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_INIT   = 3'd1;
    localparam logic [2:0] c_WAIT   = 3'd2;
    localparam logic [2:0] c_CALC   = 3'd3;
    localparam logic [2:0] c_UPDATE = 3'd4;
    localparam logic [2:0] c_FETCH  = 3'd5;
    localparam logic [2:0] c_END    = 3'd6;
    localparam logic [2:0] c_DONE   = 3'd7;

    localparam logic        [7:0]    c_MAXEP = 8'(MAX_EPOCHS);
    localparam logic signed [UW-1:0] c_ETA   = UW'(ETA);
    localparam logic signed [UW-1:0] c_WMAX  = UW'((2 ** (WW - 1)) - 1);
    localparam logic signed [UW-1:0] c_WMIN  = ~c_WMAX;

    logic        [2:0]    r_state;
    logic signed [WW-1:0] r_w1, r_w2, r_b;
    logic        [7:0]    r_epoch;
    logic                 r_changed;
    logic                 r_conv;
    logic signed [NW-1:0] r_net;

    // Dot product in a width that holds the worst-case sum exactly
    logic signed [NW-1:0] w_w1n, w_w2n, w_bn, w_x1n, w_x2n, w_net;
    assign w_w1n = {{(NW-WW){r_w1[WW-1]}}, r_w1};
    assign w_w2n = {{(NW-WW){r_w2[WW-1]}}, r_w2};
    assign w_bn  = {{(NW-WW){r_b[WW-1]}},  r_b};
    assign w_x1n = {{(NW-XW){bus.i_x1[XW-1]}}, bus.i_x1};
    assign w_x2n = {{(NW-XW){bus.i_x2[XW-1]}}, bus.i_x2};
    assign w_net = w_w1n * w_x1n + w_w2n * w_x2n + w_bn;

    logic w_tval, w_tneg, w_yneg, w_miss;
    assign w_tval = bus.i_t[0];
    assign w_tneg = bus.i_t[1];
    assign w_yneg = (r_net < 0);
    assign w_miss = w_tval && (w_yneg != w_tneg);

    // Update sums are formed wide and clamped back to WW bits
    logic signed [UW-1:0] w_x1u, w_x2u, w_w1u, w_w2u, w_bu;
    logic signed [UW-1:0] w_d1, w_d2, w_s1, w_s2, w_sb;
    assign w_x1u = {{(UW-XW){bus.i_x1[XW-1]}}, bus.i_x1};
    assign w_x2u = {{(UW-XW){bus.i_x2[XW-1]}}, bus.i_x2};
    assign w_w1u = {{(UW-WW){r_w1[WW-1]}}, r_w1};
    assign w_w2u = {{(UW-WW){r_w2[WW-1]}}, r_w2};
    assign w_bu  = {{(UW-WW){r_b[WW-1]}},  r_b};
    assign w_d1  = w_x1u * c_ETA;
    assign w_d2  = w_x2u * c_ETA;
    assign w_s1  = w_tneg ? (w_w1u - w_d1)  : (w_w1u + w_d1);
    assign w_s2  = w_tneg ? (w_w2u - w_d2)  : (w_w2u + w_d2);
    assign w_sb  = w_tneg ? (w_bu  - c_ETA) : (w_bu  + c_ETA);

    function automatic logic signed [WW-1:0] f_sat(input logic signed [UW-1:0] v);
        if (v > c_WMAX) return c_WMAX[WW-1:0];
        if (v < c_WMIN) return c_WMIN[WW-1:0];
        return v[WW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_w1      <= '0;
            r_w2      <= '0;
            r_b       <= '0;
            r_epoch   <= '0;
            r_changed <= 1'b0;
            r_conv    <= 1'b0;
            r_net     <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (bus.i_start) begin
                        r_w1      <= '0;
                        r_w2      <= '0;
                        r_b       <= '0;
                        r_epoch   <= 8'd1;
                        r_changed <= 1'b0;
                        r_conv    <= 1'b0;
                        r_state   <= c_INIT;
                    end
                end
                c_INIT:   r_state <= c_WAIT;
                c_WAIT:   r_state <= bus.i_eof ? c_END : c_CALC;
                c_CALC: begin
                    r_net   <= w_net;
                    r_state <= c_UPDATE;
                end
                c_UPDATE: begin
                    if (w_miss) begin
                        r_w1      <= f_sat(w_s1);
                        r_w2      <= f_sat(w_s2);
                        r_b       <= f_sat(w_sb);
                        r_changed <= 1'b1;
                    end
                    r_state <= c_FETCH;
                end
                c_FETCH:  r_state <= c_WAIT;
                c_END: begin
                    if (!r_changed) begin
                        r_conv  <= 1'b1;
                        r_state <= c_DONE;
                    end else if (r_epoch == c_MAXEP) begin
                        r_state <= c_DONE;
                    end else begin
                        r_changed <= 1'b0;
                        r_epoch   <= r_epoch + 8'd1;
                        r_state   <= c_INIT;
                    end
                end
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so each lasts exactly one cycle
    assign bus.o_init      = (r_state == c_INIT);
    assign bus.o_next      = (r_state == c_FETCH);
    assign bus.o_busy      = (r_state != c_IDLE) && (r_state != c_DONE);
    assign bus.o_done      = (r_state == c_DONE);
    assign bus.o_converged = r_conv;
    assign bus.o_w1        = r_w1;
    assign bus.o_w2        = r_w2;
    assign bus.o_b         = r_b;
    assign bus.o_epoch     = r_epoch;
endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_perceptron_trainer
//  Description : Scoreboard bench for two trainer configurations sharing one
//                dataset, each served by its own reader model.
//  Revision    : 1.0
// ============================================================================
module tb_perceptron_trainer;
    localparam int XW  = 7;
    localparam int ETA = 1;
    localparam int WWA = 10;
    localparam int MEA = 50;
    localparam int WWB = 4;
    localparam int MEB = 5;

    typedef struct {
        int w1; int w2; int b; int epoch; int conv; int n;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    perceptron_trainer_if #(.XW(XW), .WW(WWA)) bus_a ();
    perceptron_trainer_if #(.XW(XW), .WW(WWB)) bus_b ();

    perceptron_trainer #(.XW(XW), .WW(WWA), .MAX_EPOCHS(MEA), .ETA(ETA)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    perceptron_trainer #(.XW(XW), .WW(WWB), .MAX_EPOCHS(MEB), .ETA(ETA)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    int ds_x1[16], ds_x2[16], ds_t[16];
    int ds_n;
    int n_checks = 0;
    int n_fail   = 0;
    res_t q_a[$], q_b[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int clampv(input int v, input int ww);
        int hi = (1 << (ww - 1)) - 1;
        int lo = -(1 << (ww - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: plain perceptron training over the dataset
    function automatic res_t model(input int ww, input int maxe);
        res_t r;
        int net, y, t, ch;
        r.w1 = 0; r.w2 = 0; r.b = 0; r.epoch = 0; r.conv = 0; r.n = ds_n;
        for (int e = 1; e <= maxe; e++) begin
            ch = 0;
            for (int k = 0; k < ds_n; k++) begin
                net = r.w1 * ds_x1[k] + r.w2 * ds_x2[k] + r.b;
                y = (net >= 0) ? 1 : -1;
                if (ds_t[k] == 1 || ds_t[k] == 3) begin
                    t = (ds_t[k] == 1) ? 1 : -1;
                    if (y != t) begin
                        r.w1 = clampv(r.w1 + ETA * t * ds_x1[k], ww);
                        r.w2 = clampv(r.w2 + ETA * t * ds_x2[k], ww);
                        r.b  = clampv(r.b + ETA * t, ww);
                        ch = 1;
                    end
                end
            end
            r.epoch = e;
            if (ch == 0) begin
                r.conv = 1;
                break;
            end
        end
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t e, input int w1, input int w2,
                             input int b, input int ep, input int cv, input int ci, input int cn);
        int net;
        chk({tag, "_w1"}, w1, e.w1);
        chk({tag, "_w2"}, w2, e.w2);
        chk({tag, "_b"}, b, e.b);
        chk({tag, "_epoch"}, ep, e.epoch);
        chk({tag, "_converged"}, cv, e.conv);
        chk({tag, "_init_count"}, ci, e.epoch);
        chk({tag, "_next_count"}, cn, e.epoch * e.n);
        if (cv == 1) begin
            for (int k = 0; k < ds_n; k++) begin
                if (ds_t[k] == 1 || ds_t[k] == 3) begin
                    net = w1 * ds_x1[k] + w2 * ds_x2[k] + b;
                    chk({tag, "_classify"}, (net >= 0) ? 1 : 3, ds_t[k]);
                end
            end
        end
    endtask

    // Reader models: sample/EOF registered on the edge that sees init/next
    int ka, ra_idx, kb, rb_idx;
    always @(posedge clk) begin
        if (bus_a.o_init || bus_a.o_next) begin
            ka = bus_a.o_init ? 0 : ra_idx + 1;
            ra_idx <= ka;
            bus_a.i_eof <= (ka >= ds_n);
            if (ka < ds_n) begin
                bus_a.i_x1 <= XW'(ds_x1[ka]);
                bus_a.i_x2 <= XW'(ds_x2[ka]);
                bus_a.i_t  <= 2'(ds_t[ka]);
            end
        end
    end
    always @(posedge clk) begin
        if (bus_b.o_init || bus_b.o_next) begin
            kb = bus_b.o_init ? 0 : rb_idx + 1;
            rb_idx <= kb;
            bus_b.i_eof <= (kb >= ds_n);
            if (kb < ds_n) begin
                bus_b.i_x1 <= XW'(ds_x1[kb]);
                bus_b.i_x2 <= XW'(ds_x2[kb]);
                bus_b.i_t  <= 2'(ds_t[kb]);
            end
        end
    end

    int since_a = 100, ci_a = 0, cn_a = 0, pd_a = 0;
    always @(negedge clk) begin
        if (bus_a.i_start && !bus_a.o_busy) begin ci_a = 0; cn_a = 0; end
        since_a++;
        if (bus_a.o_init && bus_a.o_next) chk("a_overlap", 1, 0);
        if (bus_a.o_next) chk("a_next_gap", since_a, 4);
        if (bus_a.o_init) begin
            chk("a_init_gap", (since_a >= 3) ? 1 : 0, 1);
            if (ci_a == 0) begin
                chk("a_start_w1", int'(bus_a.o_w1), 0);
                chk("a_start_b", int'(bus_a.o_b), 0);
                chk("a_start_epoch", int'(bus_a.o_epoch), 1);
                chk("a_start_busy", int'(bus_a.o_busy), 1);
            end
            ci_a++;
        end
        if (bus_a.o_next) cn_a++;
        if (bus_a.o_init || bus_a.o_next) since_a = 0;
        if (bus_a.o_done && pd_a == 0) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else check_res("a", q_a.pop_front(), int'(bus_a.o_w1), int'(bus_a.o_w2),
                           int'(bus_a.o_b), int'(bus_a.o_epoch), int'(bus_a.o_converged), ci_a, cn_a);
        end
        pd_a = int'(bus_a.o_done);
    end

    int since_b = 100, ci_b = 0, cn_b = 0, pd_b = 0;
    always @(negedge clk) begin
        if (bus_b.i_start && !bus_b.o_busy) begin ci_b = 0; cn_b = 0; end
        since_b++;
        if (bus_b.o_init && bus_b.o_next) chk("b_overlap", 1, 0);
        if (bus_b.o_next) chk("b_next_gap", since_b, 4);
        if (bus_b.o_init) begin
            chk("b_init_gap", (since_b >= 3) ? 1 : 0, 1);
            if (ci_b == 0) begin
                chk("b_start_w2", int'(bus_b.o_w2), 0);
                chk("b_start_epoch", int'(bus_b.o_epoch), 1);
            end
            ci_b++;
        end
        if (bus_b.o_next) cn_b++;
        if (bus_b.o_init || bus_b.o_next) since_b = 0;
        if (bus_b.o_done && pd_b == 0) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else check_res("b", q_b.pop_front(), int'(bus_b.o_w1), int'(bus_b.o_w2),
                           int'(bus_b.o_b), int'(bus_b.o_epoch), int'(bus_b.o_converged), ci_b, cn_b);
        end
        pd_b = int'(bus_b.o_done);
    end

    task automatic add(input int x1, input int x2, input int t);
        ds_x1[ds_n] = x1; ds_x2[ds_n] = x2; ds_t[ds_n] = t;
        ds_n++;
    endtask

    task automatic set_start(input logic v);
        bus_a.i_start = v;
        bus_b.i_start = v;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_init"}, int'(bus_a.o_init), 0);
        chk({tag, "_next"}, int'(bus_a.o_next), 0);
        chk({tag, "_busy"}, int'(bus_a.o_busy), 0);
        chk({tag, "_done"}, int'(bus_a.o_done), 0);
        chk({tag, "_conv"}, int'(bus_a.o_converged), 0);
        chk({tag, "_w1"}, int'(bus_a.o_w1), 0);
        chk({tag, "_w2"}, int'(bus_a.o_w2), 0);
        chk({tag, "_b"}, int'(bus_a.o_b), 0);
        chk({tag, "_epoch"}, int'(bus_a.o_epoch), 0);
        chk({tag, "_b_busy"}, int'(bus_b.o_busy), 0);
        chk({tag, "_b_w1"}, int'(bus_b.o_w1), 0);
    endtask

    task automatic run(input bit poke);
        res_t ea, eb;
        bit ok;
        ea = model(WWA, MEA);
        eb = model(WWB, MEB);
        q_a.push_back(ea);
        q_b.push_back(eb);
        pulse_start();
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 set_start(1'b1);
            @(posedge clk); #1 set_start(1'b0);
        end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (q_a.size() == 0 && q_b.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("run_timeout", 0, 1);
            q_a.delete();
            q_b.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_start(1'b0);
        ds_n = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst");
        rst_n = 1'b1;

        // Abort a run in its first CALC cycle
        add(3, 2, 3);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.o_init) break;
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("abort");
        @(posedge clk); #1 rst_n = 1'b1;

        run(1'b0);

        ds_n = 0;
        add(-1, -1, 3); add(-1, 1, 3); add(1, -1, 3); add(1, 1, 1);
        run(1'b0);

        ds_n = 0;
        add(-1, -1, 3); add(-1, 1, 1); add(1, -1, 1); add(1, 1, 3);
        run(1'b0);

        ds_n = 0;
        add(63, 0, 3);
        run(1'b1);

        ds_n = 0;
        add(5, 5, 0); add(-7, 2, 2);
        run(1'b0);

        for (int r = 0; r < 12; r++) begin
            ds_n = 0;
            for (int k = 0; k < int'($urandom_range(8, 1)); k++)
                add(int'($urandom_range(127, 0)) - 64, int'($urandom_range(127, 0)) - 64,
                    int'($urandom_range(3, 0)));
            run(r[0]);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
